// File: rtl/dac_adc_sweep_seq_pkg.sv
// Shared definitions for the DAC/ADC sweep sequencer: FSM state encoding and
// accumulator sizing.
package dac_adc_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DSTART = 3'd1,
    S_DWAIT  = 3'd2,
    S_SETTLE = 3'd3,
    S_ASTART = 3'd4,
    S_AWAIT  = 3'd5,
    S_PUSH   = 3'd6
  } state_e;

  // Sum of 2^navg_log2 unsigned samples never overflows this width.
  function automatic int acc_width(input int adc_w, input int navg_log2);
    return adc_w + navg_log2;
  endfunction

endpackage

// File: rtl/dac_adc_sweep_seq_avg_acc.sv
// Per-point sample accumulator: clears, adds ADC samples, and presents the
// truncated mean; done_o flags that the next sample completes the set.
module avg_acc
  import dac_adc_pkg::*;
#(
  parameter int ADC_W     = 12,
  parameter int NAVG_LOG2 = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             add_i,
  input  logic [ADC_W-1:0] data_i,
  output logic [ADC_W-1:0] avg_o,
  output logic             done_o
);

  localparam int ACC_W = acc_width(ADC_W, NAVG_LOG2);
  localparam int CNT_W = NAVG_LOG2 + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'((1 << NAVG_LOG2) - 1);

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (clr_i) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (add_i) begin
      acc_d = acc_q + ACC_W'(data_i);
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == LAST);
  assign avg_o  = acc_q[ACC_W-1:NAVG_LOG2];

endmodule

// File: rtl/dac_adc_sweep_seq.sv
// Linear DAC sweep sequencer: per point, write DAC, settle, average
// 2^NAVG_LOG2 ADC conversions and emit one result on a valid/ready stream.
module dac_adc_sweep_seq
  import dac_adc_pkg::*;
#(
  parameter int DAC_W     = 12,
  parameter int ADC_W     = 12,
  parameter int NAVG_LOG2 = 2,
  parameter int NPTS_W    = 10,
  parameter int SETTLE_W  = 16,
  parameter int TO_W      = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic                abort_i,
  input  logic [DAC_W-1:0]    code_start_i,
  input  logic [DAC_W-1:0]    code_step_i,
  input  logic [NPTS_W-1:0]   npts_i,
  input  logic [SETTLE_W-1:0] settle_i,
  output logic                stdac_o,
  output logic [DAC_W-1:0]    dac_code_o,
  input  logic                eodac_i,
  output logic                stadc_o,
  input  logic                eoadc_i,
  input  logic [ADC_W-1:0]    adc_data_i,
  output logic                res_valid_o,
  input  logic                res_ready_i,
  output logic [DAC_W-1:0]    res_code_o,
  output logic [ADC_W-1:0]    res_data_o,
  output logic                busy_o,
  output logic                eoconv_o,
  output logic                err_timeout_o
);

  // Watchdog fires on the (2^TO_W-1)th waiting cycle; wd_q starts at 0.
  localparam logic [TO_W-1:0] WD_LAST = {{(TO_W-1){1'b1}}, 1'b0};

  state_e              state_q;
  logic [DAC_W-1:0]    code_q, step_q;
  logic [NPTS_W-1:0]   npts_q;
  logic [SETTLE_W-1:0] settle_cfg_q, settle_cnt_q;
  logic [TO_W-1:0]     wd_q;
  logic                err_q;

  logic             acc_clr, acc_add, acc_done;
  logic [ADC_W-1:0] acc_avg;

  assign acc_clr = (state_q == S_IDLE) || ((state_q == S_PUSH) && res_ready_i);
  assign acc_add = (state_q == S_AWAIT) && eoadc_i;

  avg_acc #(
    .ADC_W     (ADC_W),
    .NAVG_LOG2 (NAVG_LOG2)
  ) u_avg_acc (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clr_i  (acc_clr),
    .add_i  (acc_add),
    .data_i (adc_data_i),
    .avg_o  (acc_avg),
    .done_o (acc_done)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      code_q       <= '0;
      step_q       <= '0;
      npts_q       <= '0;
      settle_cfg_q <= '0;
      settle_cnt_q <= '0;
      wd_q         <= '0;
      err_q        <= 1'b0;
    end else if (abort_i) begin
      state_q <= S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i && (npts_i != '0)) begin
            code_q       <= code_start_i;
            step_q       <= code_step_i;
            npts_q       <= npts_i;
            settle_cfg_q <= settle_i;
            err_q        <= 1'b0;
            state_q      <= S_DSTART;
          end
        end
        S_DSTART: begin
          wd_q    <= '0;
          state_q <= S_DWAIT;
        end
        S_DWAIT: begin
          if (eodac_i) begin
            settle_cnt_q <= '0;
            state_q      <= (settle_cfg_q == '0) ? S_ASTART : S_SETTLE;
          end else if (wd_q == WD_LAST) begin
            err_q   <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            wd_q <= wd_q + 1'b1;
          end
        end
        S_SETTLE: begin
          if (settle_cnt_q == settle_cfg_q - SETTLE_W'(1)) state_q <= S_ASTART;
          else settle_cnt_q <= settle_cnt_q + 1'b1;
        end
        S_ASTART: begin
          wd_q    <= '0;
          state_q <= S_AWAIT;
        end
        S_AWAIT: begin
          if (eoadc_i) begin
            state_q <= acc_done ? S_PUSH : S_ASTART;
          end else if (wd_q == WD_LAST) begin
            err_q   <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            wd_q <= wd_q + 1'b1;
          end
        end
        S_PUSH: begin
          if (res_ready_i) begin
            npts_q <= npts_q - NPTS_W'(1);
            if (npts_q == NPTS_W'(1)) begin
              state_q <= S_IDLE;
            end else begin
              code_q  <= code_q + step_q;
              state_q <= S_DSTART;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign stdac_o       = (state_q == S_DSTART);
  assign stadc_o       = (state_q == S_ASTART);
  assign res_valid_o   = (state_q == S_PUSH);
  assign busy_o        = (state_q != S_IDLE);
  assign eoconv_o      = (state_q == S_IDLE);
  assign dac_code_o    = code_q;
  assign res_code_o    = code_q;
  assign res_data_o    = acc_avg;
  assign err_timeout_o = err_q;

endmodule
